// File: rtl/fptd_pkg.sv
// rtl/fptd_pkg.sv - shared types and constants for the FPTD result voter
// Purpose: lane/word widths, voter state encoding and frame constants
//          used by fptd_result_voter and majority5.
// Ports:   none (package).
package fptd_pkg;

   localparam int W  = 6;   // error count / output word width
   localparam int NL = 5;   // redundant lanes, vote threshold is 3

   typedef logic [W-1:0]  err_t;
   typedef logic [NL-1:0] lane_mask_t;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      VOTE,
      EMIT0,
      EMIT1,
      EMIT2
   } voter_state_t;

   localparam err_t NO_MAJ_CODE  = 6'h3F;
   localparam err_t MISMATCH_SAT = 6'd63;

endpackage

// File: rtl/majority5.sv
// rtl/majority5.sv - combinational 3-of-5 majority vote over captured lanes
// Purpose: finds the value held by at least three present lanes and flags
//          every lane that is missing or disagrees with it.
// Ports:   vals        in   NL x W  captured lane values
//          present     in   NL      lane was captured
//          result      out  W       majority value, NO_MAJ_CODE when none
//          no_majority out  1       no value reached three votes
//          mask        out  NL      disagreeing or missing lanes
module majority5
   import fptd_pkg::*;
(
   input  logic [NL-1:0][W-1:0] vals,
   input  lane_mask_t           present,
   output err_t                 result,
   output logic                 no_majority,
   output lane_mask_t           mask
);

   // same[i][j]: lanes i and j are both present and hold equal values.
   // Only the upper triangle is computed; the lower one mirrors it.
   logic [NL-1:0][NL-1:0] same;

   always_comb begin
      same = '0;
      for (int i = 0; i < NL; i++) begin
         for (int j = i + 1; j < NL; j++) begin
            same[i][j] = present[i] && present[j] && (vals[i] == vals[j]);
            same[j][i] = same[i][j];
         end
      end
   end

   // A present lane that matches two other lanes holds a 3-vote value.
   // With five lanes only one distinct value can get there, so the
   // scan order does not matter.
   always_comb begin
      result      = NO_MAJ_CODE;
      no_majority = 1'b1;
      mask        = '0;
      for (int i = NL - 1; i >= 0; i--) begin
         if (present[i] && ($countones(same[i]) >= 2)) begin
            result      = vals[i];
            no_majority = 1'b0;
         end
      end
      for (int i = 0; i < NL; i++) begin
         mask[i] = no_majority || !present[i] || (vals[i] != result);
      end
   end

endmodule

// File: rtl/fptd_result_voter.sv
// rtl/fptd_result_voter.sv - majority voter and result framer for five FPTD engines
// Purpose: captures each engine's error count, votes, and emits a 3-word
//          frame {result, {no_majority, mask}, mismatch count}.
// Ports:   Clock       in   1        system clock
//          nReset      in   1        asynchronous active-low reset
//          Start       in   1        frame launch pulse
//          Valid_Data  in   NL       per-lane result valid
//          Errors      in   NL x W   per-lane error counts
//          DOut        out  W        frame word
//          DOutValid   out  1        high for each frame word
//          Busy        out  1        high outside IDLE
//          NoMajority  out  1        last vote found no 3-vote value
module fptd_result_voter
   import fptd_pkg::*;
#(
   parameter int TMAX = 255
)
(
   input  logic                 Clock,
   input  logic                 nReset,
   input  logic                 Start,
   input  logic [NL-1:0]        Valid_Data,
   input  logic [NL-1:0][W-1:0] Errors,
   output err_t                 DOut,
   output logic                 DOutValid,
   output logic                 Busy,
   output logic                 NoMajority
);

   localparam int              TW     = $clog2(TMAX + 1);
   localparam logic [TW-1:0]   T_LAST = TW'(TMAX - 1);

   voter_state_t         state, next_state;
   lane_mask_t           flags;
   logic [NL-1:0][W-1:0] cap_vals;
   logic [TW-1:0]        timer;
   lane_mask_t           mask_r;
   err_t                 mismatch_cnt;

   err_t                 vote_result;
   logic                 vote_no_maj;
   lane_mask_t           vote_mask;

   // Lanes whose valid arrives this cycle count as captured for the exit test,
   // so VOTE follows the last valid by exactly one cycle.
   logic                 all_in;
   assign all_in = &(flags | Valid_Data);

   majority5 u_majority5 (
      .vals        (cap_vals),
      .present     (flags),
      .result      (vote_result),
      .no_majority (vote_no_maj),
      .mask        (vote_mask)
   );

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (Start) next_state = COLLECT;
         COLLECT: if (all_in || (timer == T_LAST)) next_state = VOTE;
         VOTE:    next_state = EMIT0;
         EMIT0:   next_state = EMIT1;
         EMIT1:   next_state = EMIT2;
         EMIT2:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output words are loaded one state ahead so DOut/DOutValid are
   // registered yet line up with the EMIT states.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         flags        <= '0;
         cap_vals     <= '0;
         timer        <= '0;
         mask_r       <= '0;
         mismatch_cnt <= '0;
         DOut         <= '0;
         DOutValid    <= 1'b0;
         Busy         <= 1'b0;
         NoMajority   <= 1'b0;
      end else begin
         Busy      <= (next_state != IDLE);
         DOutValid <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  flags    <= '0;
                  cap_vals <= '0;
                  timer    <= '0;
               end
            end
            COLLECT: begin
               timer <= timer + 1'b1;
               for (int i = 0; i < NL; i++) begin
                  if (Valid_Data[i] && !flags[i]) begin
                     flags[i]    <= 1'b1;
                     cap_vals[i] <= Errors[i];
                  end
               end
            end
            VOTE: begin
               DOut       <= vote_result;
               DOutValid  <= 1'b1;
               NoMajority <= vote_no_maj;
               mask_r     <= vote_mask;
               if ((vote_mask != '0) && (mismatch_cnt != MISMATCH_SAT)) begin
                  mismatch_cnt <= mismatch_cnt + 1'b1;
               end
            end
            EMIT0: begin
               DOut      <= {NoMajority, mask_r};
               DOutValid <= 1'b1;
            end
            EMIT1: begin
               DOut      <= mismatch_cnt;
               DOutValid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fptd_result_voter.sv
// tb/tb_fptd_result_voter.sv - self-checking bench for fptd_result_voter
// Purpose: directed and random frames checked against a vote-counting model.
// Ports:   none (top-level bench).
module tb_fptd_result_voter;

   localparam int NL   = 5;
   localparam int TMAX = 8;
   localparam int MISSING = TMAX + 20;

   logic                 Clock = 1'b0;
   logic                 nReset;
   logic                 Start;
   logic [NL-1:0]        Valid_Data;
   logic [NL-1:0][5:0]   Errors;
   logic [5:0]           DOut;
   logic                 DOutValid;
   logic                 Busy;
   logic                 NoMajority;

   int         n_checks = 0;
   int         n_errors = 0;

   // Per-lane schedule: COLLECT cycle index of first valid (>= TMAX: never).
   int         lane_t [NL];
   logic [5:0] lane_v [NL];
   int         exp_cnt = 0;
   logic       exp_nm  = 1'b0;

   always #5 Clock = ~Clock;

   fptd_result_voter #(.TMAX(TMAX)) dut (
      .Clock      (Clock),
      .nReset     (nReset),
      .Start      (Start),
      .Valid_Data (Valid_Data),
      .Errors     (Errors),
      .DOut       (DOut),
      .DOutValid  (DOutValid),
      .Busy       (Busy),
      .NoMajority (NoMajority)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive_lanes(input int n, input bit rep);
      Valid_Data = '0;
      for (int i = 0; i < NL; i++) begin
         if (lane_t[i] == n) begin
            Valid_Data[i] = 1'b1;
            Errors[i]     = lane_v[i];
         end else if (rep && (lane_t[i] + 2 == n)) begin
            Valid_Data[i] = 1'b1;
            Errors[i]     = ~lane_v[i];
         end else begin
            Errors[i] = 6'($urandom);
         end
      end
   endtask

   // start_mode: 0 none, 2 extra Start during EMIT1, 3 during EMIT2.
   task automatic run_frame(input bit rep, input int start_mode);
      int         e;
      int         got;
      int         votes;
      bit         all_in;
      logic [5:0] res;
      logic       nm;
      logic [4:0] msk;

      all_in = 1'b1;
      e = 0;
      for (int i = 0; i < NL; i++) begin
         if (lane_t[i] >= TMAX) all_in = 1'b0;
         else if (lane_t[i] > e) e = lane_t[i];
      end
      if (!all_in) e = TMAX - 1;

      nm  = 1'b1;
      res = 6'h3F;
      for (int i = 0; i < NL; i++) begin
         if (lane_t[i] < TMAX) begin
            votes = 0;
            for (int j = 0; j < NL; j++)
               if (lane_t[j] < TMAX && lane_v[j] == lane_v[i]) votes++;
            if (votes >= 3) begin
               nm  = 1'b0;
               res = lane_v[i];
            end
         end
      end
      for (int i = 0; i < NL; i++)
         msk[i] = nm || (lane_t[i] >= TMAX) || (lane_v[i] != res);
      if (msk != 0 && exp_cnt < 63) exp_cnt++;

      @(negedge Clock);
      Start      = 1'b1;
      Valid_Data = '0;
      got = 0;
      for (int n = 0; n < TMAX + 10 && got < 3; n++) begin
         @(negedge Clock);
         check("busy", Busy, 1);
         if (n == 0) check("nomaj_hold", NoMajority, exp_nm);
         if (DOutValid) begin
            case (got)
               0: begin
                  check("latency", n, e + 2);
                  check("word_result", DOut, res);
                  check("nomaj", NoMajority, nm);
               end
               1: check("word_mask", DOut, {nm, msk});
               default: check("word_count", DOut, exp_cnt);
            endcase
            got++;
         end
         drive_lanes(n, rep);
         Start = (start_mode != 0) && (got == start_mode);
      end
      if (got < 3) check("frame_words", got, 3);

      @(negedge Clock);
      check("idle_valid", DOutValid, 0);
      check("idle_busy", Busy, 0);
      check("idle_hold", DOut, exp_cnt);
      check("idle_nomaj", NoMajority, nm);
      Start      = 1'b0;
      Valid_Data = '0;
      exp_nm     = nm;
   endtask

   task automatic set_frame(input int t0, t1, t2, t3, t4,
                            input logic [5:0] v0, v1, v2, v3, v4);
      lane_t[0] = t0; lane_t[1] = t1; lane_t[2] = t2; lane_t[3] = t3; lane_t[4] = t4;
      lane_v[0] = v0; lane_v[1] = v1; lane_v[2] = v2; lane_v[3] = v3; lane_v[4] = v4;
   endtask

   task automatic reset_mid_frame();
      @(negedge Clock);
      Start = 1'b1;
      @(negedge Clock);
      Start      = 1'b0;
      Valid_Data = 5'b00011;
      Errors     = {NL{6'd9}};
      @(negedge Clock);
      Valid_Data = '0;
      check("mid_busy", Busy, 1);
      nReset = 1'b0;
      #1;
      check("rst_dout", DOut, 0);
      check("rst_valid", DOutValid, 0);
      check("rst_busy", Busy, 0);
      check("rst_nomaj", NoMajority, 0);
      @(negedge Clock);
      @(negedge Clock);
      nReset  = 1'b1;
      exp_cnt = 0;
      exp_nm  = 1'b0;
      repeat (TMAX + 6) begin
         @(negedge Clock);
         check("post_rst_valid", DOutValid, 0);
         check("post_rst_busy", Busy, 0);
      end
   endtask

   initial begin
      nReset     = 1'b0;
      Start      = 1'b0;
      Valid_Data = '0;
      Errors     = '0;
      repeat (2) @(negedge Clock);
      check("reset_dout", DOut, 0);
      check("reset_valid", DOutValid, 0);
      check("reset_busy", Busy, 0);
      check("reset_nomaj", NoMajority, 0);
      nReset = 1'b1;

      set_frame(0, 0, 0, 0, 0, 12, 12, 12, 12, 12);
      run_frame(1'b0, 0);
      set_frame(0, 1, 2, 3, 1, 7, 7, 7, 9, 7);
      run_frame(1'b0, 0);
      set_frame(0, 0, 0, 0, 0, 1, 2, 3, 1, 2);
      run_frame(1'b0, 0);
      set_frame(0, 1, 2, MISSING, MISSING, 5, 5, 5, 5, 5);
      run_frame(1'b0, 0);
      set_frame(0, 0, 1, 2, 0, 4, 4, 4, 4, 4);
      run_frame(1'b1, 2);
      set_frame(MISSING, MISSING, MISSING, MISSING, MISSING, 0, 0, 0, 0, 0);
      run_frame(1'b0, 3);
      set_frame(1, 0, 3, 0, 2, 20, 21, 20, 21, 20);
      run_frame(1'b1, 0);

      for (int f = 0; f < 30; f++) begin
         for (int i = 0; i < NL; i++) begin
            lane_t[i] = ($urandom_range(0, 7) == 0) ? MISSING : int'($urandom_range(0, TMAX - 1));
            lane_v[i] = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 2));
         end
         run_frame(1'($urandom_range(0, 1)), (f % 3 == 0) ? 0 : int'($urandom_range(2, 3)));
      end

      reset_mid_frame();

      for (int f = 0; f < 65; f++) begin
         for (int i = 0; i < NL; i++) begin
            lane_t[i] = 0;
            lane_v[i] = 6'($urandom_range(0, 3));
         end
         lane_v[4] = lane_v[0] + 6'd1;
         run_frame(1'b0, 0);
      end
      check("mismatch_sat", DOut, 63);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fptd_result_voter.md
Name: fptd_result_voter

Overview:
- Downstream stage of the five redundant FPTD error-test engines.
- Captures each engine's 6-bit error count when its Valid_Data asserts, and majority-votes the five values.
- Flags the lanes that disagree with the majority.
- Emits a 3-word result frame on a 6-bit output port for the chip pins, plus a sticky mismatch counter for radiation/fault monitoring.

Parameters:
- W, 6, width of each error count and of the output word.
- NL, 5, number of redundant lanes (fixed at 5; voting threshold is 3).
- TMAX, 255, collection timeout in Clock cycles; the timer width is ceil(log2(TMAX+1)).

Ports:
- Clock  in  1  system clock.
- nReset  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse; the same Start that launches the FPTD engines.
- Valid_Data  in  NL  per-lane result valid, level or pulse.
- Errors  in  NL x W  per-lane error counts; lane i is on Errors[i].
- DOut  out  W  frame word.
- DOutValid  out  1  high for each frame word.
- Busy  out  1  high in every state except IDLE.
- NoMajority  out  1  registered; set when no value reaches 3 votes.

Behaviour:
- Reset is asynchronous, active-low on nReset; clock is Clock. All registers go to 0: state=IDLE, DOut=0, DOutValid=0, Busy=0, NoMajority=0, capture flags=0, timer=0, MismatchCnt=0.
- States and transitions:
  - IDLE: Start=1 -> COLLECT. On that entry edge, clear the capture flags, captured values and timer.
  - COLLECT: on each edge, lane i with Valid_Data[i]=1 and flag[i]=0 latches Errors[i] and sets flag[i]. A lane is captured once only; later Valid_Data pulses are ignored.
  - COLLECT exit: if (flag | Valid_Data)==all ones -> VOTE. Otherwise, when timer==TMAX-1 -> VOTE, with the uncaptured lanes marked missing. The timer increments every COLLECT cycle.
  - VOTE: exactly one cycle. Among the captured lanes only, Result = a value held by >=3 lanes. Use 10 pairwise equality compares; at most one value can qualify.
    - No qualifying value: Result=6'h3F and NoMajority=1.
    - Mask[i]=1 if lane i is missing or its value != Result. When NoMajority=1, Mask=5'b11111.
    - If Mask!=0, MismatchCnt increments, saturating at 63. MismatchCnt is cleared only by reset.
  - VOTE -> EMIT0.
  - EMIT0: DOut=Result. EMIT1: DOut={NoMajority,Mask}. EMIT2: DOut=MismatchCnt. DOutValid=1 in all three.
  - EMIT0 -> EMIT1 -> EMIT2 -> IDLE.
- Outputs are registered. Outside the EMIT states, DOutValid=0 and DOut holds its last value.
- Latency: if the last lane's Valid_Data is high in cycle c, VOTE occupies c+1 and DOutValid is high in cycles c+2, c+3 and c+4. Best case is all lanes valid in the first COLLECT cycle.
- Start while Busy is ignored and the current frame completes. Start in the same cycle as the EMIT2->IDLE edge is also ignored.
- Valid_Data in IDLE, VOTE or EMIT is ignored.
- Timeout with zero lanes captured: NoMajority=1, Result=6'h3F, Mask=5'b11111.
- nReset asserted mid-frame aborts immediately. No partial frame is emitted after release.
- NoMajority is updated in VOTE and holds until the next VOTE.

Decomposition:
- Shared package fptd_pkg:
  - typedef err_t = logic [W-1:0].
  - typedef lane_mask_t = logic [NL-1:0].
  - enum voter_state_t {IDLE, COLLECT, VOTE, EMIT0, EMIT1, EMIT2}.
  - Constants NO_MAJ_CODE=6'h3F and MISMATCH_SAT=63.
- One sub-module, majority5: purely combinational. Inputs are 5 values plus a present mask; outputs are Result, NoMajority and Mask. It is instantiated once and registered in VOTE.

Test Plan:
- All lanes agree: Start; next cycle all Valid_Data high with Errors all 6'd12 -> frame 12, 6'b000000, 0; DOutValid high exactly 3 cycles, starting 2 cycles after Valid.
- One faulty lane: lanes={7,7,7,9,7}, valid staggered over 4 cycles -> frame 7, 6'b001000, 1; VOTE follows the last valid by one cycle.
- No majority: lanes={1,2,3,1,2} -> frame 63, 6'b111111, count+1; NoMajority=1 and stays until the next VOTE.
- Timeout, set TMAX=8: only lanes 0-2 valid with value 5 -> VOTE after 8 COLLECT cycles; frame 5, 6'b011000.
- Robustness: second Start during EMIT1 -> ignored, Busy low after EMIT2. Repeated Valid_Data pulses on lane 0 with changed Errors -> first captured value is kept.
- Reset mid-COLLECT -> all outputs 0, no frame emitted. Run 65 mismatching frames -> MismatchCnt saturates at 63.
